// File: rtl/data_mem_if.sv
// Data-memory request/response bundle between the MEM stage (master) and the responder (slave).
// The misalign signal exists only when DMEM_MISALIGN_TRAP_EN is defined.
interface data_mem_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        memready;
`ifdef DMEM_MISALIGN_TRAP_EN
  logic        misalign;

  modport master (output req, we, addr, wdata, input rdata, memready, misalign);
  modport slave  (input req, we, addr, wdata, output rdata, memready, misalign);
`else
  modport master (output req, we, addr, wdata, input rdata, memready);
  modport slave  (input req, we, addr, wdata, output rdata, memready);
`endif
endinterface

// File: rtl/data_mem_responder.sv
// Multi-cycle word-addressed data memory: one access in flight, completion after LATENCY cycles.
// Optional build macro DMEM_MISALIGN_TRAP_EN adds misaligned-access trapping and the misalign output.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 4
) (
  input logic         clk,
  input logic         reset,
  data_mem_if.slave   bus
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (LATENCY <= 2) ? 1 : $clog2(LATENCY);
  localparam logic [CW-1:0] CNT_INIT = (LATENCY >= 2) ? CW'(LATENCY - 2) : '0;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            we_q;
  logic [AW-1:0]   idx_q;
  logic [31:0]     wdata_q;
  logic            mis_q;
  logic [31:0]     rdata_q;
  logic [31:0]     mem [DEPTH_WORDS];

  logic [AW-1:0]   idx_in;
  logic            mis_in;
  logic            unused_addr;

  assign idx_in      = bus.addr[AW+1:2];
  assign unused_addr = ^bus.addr;

`ifdef DMEM_MISALIGN_TRAP_EN
  assign mis_in       = |bus.addr[1:0];
  assign bus.misalign = (state == DONE) && mis_q;
`else
  assign mis_in = 1'b0;
`endif

  // The stall must assert in the same cycle a request first appears, so this stays combinational.
  assign bus.memready = ((state == IDLE) && !bus.req) || (state == DONE);
  assign bus.rdata    = rdata_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      mis_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req) begin
            we_q    <= bus.we;
            idx_q   <= idx_in;
            wdata_q <= bus.wdata;
            mis_q   <= mis_in;
            if (LATENCY == 1) begin
              // Single-cycle latency reads straight from the live request.
              state <= DONE;
              if (!bus.we) rdata_q <= mis_in ? 32'h0 : mem[idx_in];
            end else begin
              state <= BUSY;
              cnt   <= CNT_INIT;
            end
          end
        end
        BUSY: begin
          if (cnt == '0) begin
            state <= DONE;
            if (!we_q) rdata_q <= mis_q ? 32'h0 : mem[idx_q];
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Storage is never reset; a reset that aborts DONE leaves the state IDLE so no write occurs.
  always_ff @(posedge clk) begin
    if ((state == DONE) && we_q && !mis_q) mem[idx_q] <= wdata_q;
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: LATENCY=4 instance for the main sequences, LATENCY=1 for aliasing.
module tb_data_mem_responder;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  data_mem_if bus();
  data_mem_if bus1();

  data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(4)) dut  (.clk(clk), .reset(reset), .bus(bus));
  data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  int          checks = 0;
  int          errors = 0;
  logic [31:0] model [256];
  logic [31:0] exp_q [$];
  logic [31:0] last_rd;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_mis(input string tag, input logic exp);
`ifdef DMEM_MISALIGN_TRAP_EN
    chk(tag, 32'(bus.misalign), 32'(exp));
`else
    if (exp) chk(tag, 32'd0, 32'd1);
`endif
  endtask

  // One full access on the LATENCY=4 port; req is held through DONE like a stalled MEM stage.
  task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d, input bit scr);
    bit          mis;
    logic [31:0] rd_exp;
    mis = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
    mis = (a[1:0] != 2'b00);
`endif
    @(negedge clk);
    bus.req = 1'b1; bus.we = w; bus.addr = a; bus.wdata = d;
    if (w) begin
      if (!mis) model[a[9:2]] = d;
    end else begin
      exp_q.push_back(mis ? 32'h0 : model[a[9:2]]);
    end
    #1 chk("rdy_accept", 32'(bus.memready), 32'd0);
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      if (scr) begin
        bus.we = 1'b1; bus.addr = 32'h20; bus.wdata = 32'hBAD0_BAD0;
      end
      #1 chk("rdy_busy", 32'(bus.memready), 32'd0);
      chk_mis("mis_busy", 1'b0);
    end
    @(negedge clk);
    #1 chk("rdy_done", 32'(bus.memready), 32'd1);
    chk_mis("mis_done", mis);
    if (!w) begin
      rd_exp = exp_q.pop_front();
      chk("rdata_load", bus.rdata, rd_exp);
      last_rd = rd_exp;
    end else begin
      chk("rdata_hold", bus.rdata, last_rd);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      bus.req = 1'b0; bus.we = 1'b0;
      #1 chk("rdy_idle", 32'(bus.memready), 32'd1);
      chk("rdata_idle", bus.rdata, last_rd);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 256; i++) model[i] = 32'h0;
    last_rd = 32'h0;
    bus.req = 1'b0;  bus.we = 1'b0;  bus.addr = '0;  bus.wdata = '0;
    bus1.req = 1'b0; bus1.we = 1'b0; bus1.addr = '0; bus1.wdata = '0;
    reset = 1'b0;
    #1;
    chk("rst_rdy", 32'(bus.memready), 32'd1);
    chk("rst_rdata", bus.rdata, 32'h0);
    chk_mis("rst_mis", 1'b0);
    bus.req = 1'b1;
    #1 chk("rst_rdy_req", 32'(bus.memready), 32'd0);
    bus.req = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Store then load the same word.
    access(1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0);
    idle(1);
    access(1'b0, 32'h10, 32'h0, 1'b0);
    idle(2);

    // Inputs scrambled while BUSY must not affect the latched load or write 0x20.
    access(1'b1, 32'h20, 32'h0, 1'b0);
    access(1'b0, 32'h10, 32'h0, 1'b1);
    idle(1);
    access(1'b0, 32'h20, 32'h0, 1'b0);

    // Back-to-back store then load.
    access(1'b1, 32'h04, 32'h1, 1'b0);
    access(1'b0, 32'h04, 32'h0, 1'b0);
    idle(1);

    // Reset in the middle of a store to 0x08.
    access(1'b1, 32'h08, 32'h0, 1'b0);
    idle(1);
    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b1; bus.addr = 32'h08; bus.wdata = 32'h55;
    repeat (2) @(negedge clk);
    reset = 1'b0; bus.req = 1'b0; bus.we = 1'b0;
    #1 chk("abort_rdy", 32'(bus.memready), 32'd1);
    chk("abort_rdata", bus.rdata, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    last_rd = 32'h0;
    idle(1);
    access(1'b0, 32'h08, 32'h0, 1'b0);

    // Mixed random traffic over a small window of words.
    for (int i = 0; i < 10; i++) begin
      logic [31:0] ra;
      ra = {24'h0, 2'b0, 4'($urandom_range(0, 15)), 2'b00};
      access(1'($urandom_range(0, 1)), ra, $urandom, 1'b0);
      if (i % 3 == 0) idle(1);
    end
    idle(1);

`ifdef DMEM_MISALIGN_TRAP_EN
    access(1'b1, 32'h0C, 32'h0000_0333, 1'b0);
    access(1'b1, 32'h0D, 32'h0000_0777, 1'b0);
    access(1'b0, 32'h0C, 32'h0, 1'b0);
    access(1'b0, 32'h0E, 32'h0, 1'b0);
    idle(1);
`endif

    // LATENCY=1 instance: 0x400 aliases word 0 in a 256-word memory.
    @(negedge clk);
    bus1.req = 1'b1; bus1.we = 1'b1; bus1.addr = 32'h0; bus1.wdata = 32'hA5A5_A5A5;
    #1 chk("l1_st_accept", 32'(bus1.memready), 32'd0);
    @(negedge clk);
    #1 chk("l1_st_done", 32'(bus1.memready), 32'd1);
    @(negedge clk);
    bus1.we = 1'b0; bus1.addr = 32'h400;
    #1 chk("l1_ld_accept", 32'(bus1.memready), 32'd0);
    @(negedge clk);
    #1 chk("l1_ld_done", 32'(bus1.memready), 32'd1);
    chk("l1_alias_rdata", bus1.rdata, 32'hA5A5_A5A5);
    @(negedge clk);
    bus1.req = 1'b0;
    #1 chk("l1_idle", 32'(bus1.memready), 32'd1);
    chk("l1_rdata_hold", bus1.rdata, 32'hA5A5_A5A5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Multi-cycle data-memory responder on the memory side of the pipeline's data-memory interface. Accepts one load or store request from the MEM stage, services it after a configurable latency, and drives `memready`, which the hazard logic uses to stall the pipeline while an access is outstanding. Word-addressed synchronous storage is internal; the block replaces the single-cycle data memory behind the pipelined datapath.

## Interface
- `DEPTH_WORDS`, 256: storage depth in 32-bit words; power of two, ≥ 2.
- `LATENCY`, 4: cycles from request acceptance to completion; ≥ 1.
- `AW`, $clog2(DEPTH_WORDS): word-index width (derived; not overridden).

- `clk` input 1: single clock; all state updates on rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `req` input 1: MEM stage holds a load or store (`memtoregm | memwritem`).
- `we` input 1: request is a store (`memwritem`).
- `addr` input 32: byte address (ALU result in MEM).
- `wdata` input 32: store data.
- `rdata` output 32: load data, registered.
- `memready` output 1: high = no access outstanding or access completing this cycle; low = stall MEM and earlier stages.
- `misalign` output 1: present only with `DMEM_MISALIGN_TRAP_EN`.

## Operation
- FSM states: IDLE, BUSY, DONE. Counter `cnt`, width enough for `LATENCY-1`.
- IDLE, `req`=0: stay IDLE; `memready`=1.
- IDLE, `req`=1: latch `we`, `addr[AW+1:2]`, `wdata` into request registers; `memready`=0 this cycle (combinational from `req`). Next state: DONE if `LATENCY`=1, else BUSY with `cnt`=`LATENCY`-2.
- BUSY: `memready`=0; if `cnt`=0 → DONE, else `cnt`--. Input changes on `req/we/addr/wdata` ignored (latched copy used).
- Transition into DONE: if latched op is a load, `rdata` ← `mem[idx]`.
- DONE: `memready`=1 for exactly one cycle; at the closing edge a latched store writes `mem[idx]` ← latched `wdata`; next state IDLE unconditionally.
- `memready` = (IDLE & ~`req`) | DONE.
- `rdata` holds its last load value through stores and idle cycles.
- Address: word index = `addr[AW+1:2]`; bits above wrap silently; `addr[1:0]` ignored (default build).
- Back-to-back requests: the new instruction's `req` is first seen in the IDLE cycle after DONE; no request is lost or double-serviced.
- Storage contents not reset; simulation initial value zero.

## Timing
- Reset (async, `reset`=0): state IDLE, `cnt`=0, request registers 0, `rdata`=0, `memready` follows `req` (IDLE rule), `misalign`=0.
- Reset mid-access: access aborted; pending store never written; `rdata` cleared.
- Request accepted at edge ending cycle 0; `memready` low cycles 0..`LATENCY`-1, high in cycle `LATENCY`; load data valid on `rdata` in cycle `LATENCY`.
- Occupancy per access: `LATENCY`+1 cycles; peak throughput one access per `LATENCY`+1 cycles.
- Store visible to a following load at its first read (write edge precedes next acceptance).

## Configuration
- `DMEM_MISALIGN_TRAP_EN` defined: `misalign` output exists; at acceptance, `addr[1:0]`≠0 sets latched misalign flag; access runs full latency, store is suppressed, load returns 32'h0000_0000; `misalign`=1 only during that access's DONE cycle.
- Not defined: no `misalign` port; low address bits ignored, access proceeds on truncated word index.

## Test plan
- Reset then `LATENCY`=4, store `addr`=0x10, `wdata`=0xDEADBEEF: `memready` low 4 cycles, high cycle 4; later load 0x10 → `rdata`=0xDEADBEEF in its cycle 4.
- Load with `addr`/`we` changed during BUSY (to 0x20, 1): original load serviced, no write to 0x20 (subsequent load 0x20 → 0).
- Back-to-back store 0x04=0x1 then load 0x04: second `memready` low from cycle 5; `rdata`=0x1 at cycle 9.
- `reset` pulsed low in BUSY of store 0x08=0x55: `memready` returns to IDLE behaviour immediately, `rdata`=0; load 0x08 → 0.
- `LATENCY`=1 and `DEPTH_WORDS`=256: load `addr`=0x400 aliases word 0; `memready` low 1 cycle.
- `DMEM_MISALIGN_TRAP_EN`: store `addr`=0x0D → `misalign`=1 in DONE only, word 3 unchanged; load 0x0E → `rdata`=0.
